inner_product_seq_ctrl: RTL
===========================

# inner_product_seq_ctrl

Sequencer that computes a long signed dot product by streaming 4-lane activation/weight chunks from two read-only buffers into the external `inner_product_4x16` PE. It accumulates the PE's 32-bit partial sums into a wide accumulator and reports the final sum with a done pulse. It sits between the layer controller (start/config) and the activation/weight buffers plus the PE.

## Interface
- `ADDR_W`, 8: buffer address width; one address holds one 4-lane chunk.
- `LEN_W`, 8: width of the chunk count.
- `ACC_W`, 40: accumulator and result width; must be ≥ 32.
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: request a job; sampled only in IDLE.
- `abort` in 1: cancel the running job.
- `act_base` in ADDR_W: first activation chunk address.
- `wgt_base` in ADDR_W: first weight chunk address.
- `num_chunks` in LEN_W: N, the number of 4-element chunks.
- `busy` out 1: high in FETCH and DRAIN.
- `done` out 1: one-cycle pulse when the job completes.
- `result` out ACC_W: signed final sum.
- `result_valid` out 1: `result` is valid; held until the next accepted start or abort.
- `act_rd_en`, `wgt_rd_en` out 1: buffer read strobes.
- `act_rd_addr`, `wgt_rd_addr` out ADDR_W: buffer read addresses.
- `act_rd_data`, `wgt_rd_data` in 64: four packed signed 16-bit lanes; lane i is bits [16i+15:16i]. Read latency is 1 cycle.
- `pe_enable` out 1: PE enable.
- `pe_act`, `pe_wgt` out 64: packed lanes to the PE.
- `pe_result` in 32: signed PE result.

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - `start`=1 with N>0: latch the bases and N, clear the accumulator, drop `result_valid`, go to FETCH.
  - `start`=1 with N=0: go to DONE with the accumulator cleared.
- FETCH: issue one read per cycle for k=0..N-1.
  - `act_rd_addr` = `act_base`+k, `wgt_rd_addr` = `wgt_base`+k, both modulo 2^ADDR_W (wrap-around is legal).
  - Go to DRAIN after issuing k=N-1.
- DRAIN: wait until the valid pipeline is empty, then go to DONE.
- DONE: `done`=1 and `result_valid`=1 for one cycle, then go to IDLE.
- `pe_enable` is held at 1 for every cycle in FETCH and DRAIN. The PE only advances its result on enabled edges, so it must stay enabled to flush. In IDLE and DONE, `pe_enable`=0.
- `pe_act`/`pe_wgt` equal the read data in the cycle after a read was issued; otherwise they are 0.
- A 3-stage valid pipeline (read issued → data at PE input → PE result) gates accumulation. `pe_result` is added only when stage 3 is valid, so stale PE contents from a previous job are never summed.
- Arithmetic: `acc` += sign_extend(`pe_result`) to ACC_W. The sum wraps modulo 2^ACC_W; there is no saturation.
- `abort`: checked in FETCH and DRAIN; it takes priority over state progress.
  - Next state is IDLE. `busy`=0 next cycle.
  - No `done` pulse; `result_valid` stays 0.
  - The valid pipeline is flushed.
- `start` outside IDLE is ignored. `abort` in IDLE or DONE is ignored.

## Timing
- `start` is accepted in cycle S. FETCH runs in cycles S+1 .. S+N.
- Chunk k: read issued in cycle S+1+k, data presented to the PE in S+2+k, PE result seen in S+4+k.
- Chunk k is accumulated at the edge ending cycle S+4+k.
- `done` is asserted in cycle S+N+4, with `result` stable.
- N=0: `done` is asserted in cycle S+1 with `result`=0.
- Back-to-back jobs: a new `start` is accepted in the cycle after DONE at the earliest.
- Reset values: every output is 0 (`busy`, `done`, `result`, `result_valid`, read strobes and addresses, `pe_*`). State is IDLE.
- Reset asserted mid-job: all outputs clear immediately (asynchronous). No `done` follows.

## Structure
- Package `ip_seq_pkg`:
  - state enum
  - `LANES`=4, `LANE_W`=16, `PE_RES_W`=32, `PE_LAT`=2
  - the packed-lane slicing helper
- Sub-module `ip_seq_accum`: the valid shift pipeline, the sign-extending accumulator and the clear/flush controls. The FSM and address counters stay in the top level.
- The PE is instantiated outside this block. The bench wraps the controller plus the PE plus buffer models.

## Test plan
- N=1, act=[1,2,3,4], wgt=[5,6,7,8] at base 0 → `done` at S+5, `result`=70, `pe_enable` high for cycles S+1..S+4.
- N=3, all lanes act=1, wgt=1, `act_base`=254, `wgt_base`=10 → act addresses 254, 255, 0; wgt addresses 10, 11, 12; `result`=12 at S+7.
- N=2, act lanes all −1, wgt lanes all 32767 → `result`=−262136; sign extension into bits [39:32] verified.
- N=0 → `done` at S+1, `result`=0, no read strobes. A `start` during the busy phase of a prior N=4 job is ignored.
- N=4 job with `abort` at S+3 → `busy`=0 at S+4, no `done`, `result_valid`=0. The next job (N=1, result 70) returns 70, proving no stale accumulation.
- `reset` pulled low at S+2 of an N=5 job → all outputs 0 that cycle, state IDLE. The subsequent N=1 job is correct.

Source files
------------

// File: rtl/ip_seq_pkg.sv
// Shared types and constants for the inner-product sequencer.
// Contents: FSM state enum, PE lane geometry, PE latency, and a helper that
// extracts one signed 16-bit lane from a packed 4-lane bus.
package ip_seq_pkg;

    localparam int unsigned LANES      = 4;
    localparam int unsigned LANE_W     = 16;
    localparam int unsigned LANE_BUS_W = LANES * LANE_W;
    localparam int unsigned PE_RES_W   = 32;
    localparam int unsigned PE_LAT     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Lane idx occupies bits [16*idx+15 : 16*idx] of the packed bus.
    function automatic logic signed [LANE_W-1:0] lane_of(
        input logic [LANE_BUS_W-1:0] v,
        input logic [1:0]            idx
    );
        return v[{idx, 4'b0000} +: LANE_W];
    endfunction

endpackage

// File: rtl/ip_seq_accum.sv
// Valid pipeline and wide accumulator for the inner-product sequencer.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_issue      : a buffer read is being issued this cycle
//   i_clear      : job accepted; zero the accumulator and pipeline
//   i_flush      : job aborted; drop every in-flight valid bit
//   i_pe_result  : signed PE partial sum
//   o_vld        : valid pipeline (bit0 = data at PE input, top bit = PE result)
//   o_acc        : running signed sum, wraps modulo 2^ACC_W
import ip_seq_pkg::*;

module ip_seq_accum #(
    parameter int unsigned ACC_W = 40
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_issue,
    input  logic                i_clear,
    input  logic                i_flush,
    input  logic [PE_RES_W-1:0] i_pe_result,
    output logic [PE_LAT:0]     o_vld,
    output logic [ACC_W-1:0]    o_acc
);

    logic [PE_LAT:0]  r_vld;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_pe_ext;

    assign w_pe_ext = ACC_W'($signed(i_pe_result));

    // Only sum PE output that belongs to a read of the current job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_acc <= '0;
        end else begin
            if (i_clear || i_flush) begin
                r_vld <= '0;
            end else begin
                r_vld <= {r_vld[PE_LAT-1:0], i_issue};
            end
            if (i_clear) begin
                r_acc <= '0;
            end else if (r_vld[PE_LAT]) begin
                r_acc <= r_acc + w_pe_ext;
            end
        end
    end

    assign o_vld = r_vld;
    assign o_acc = r_acc;

endmodule

// File: rtl/inner_product_seq_ctrl.sv
// Streams N 4-lane activation/weight chunks into an external PE and
// accumulates the PE partial sums into a wide signed result.
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   start, abort               : job request / cancel from layer controller
//   act_base, wgt_base         : first chunk addresses (wrap modulo 2^ADDR_W)
//   num_chunks                 : chunk count N
//   busy, done                 : job running / one-cycle completion pulse
//   result, result_valid       : final signed sum and its qualifier
//   act_rd_*, wgt_rd_*         : buffer read ports, 1-cycle read latency
//   pe_enable, pe_act, pe_wgt  : PE drive; pe_result: PE output
import ip_seq_pkg::*;

module inner_product_seq_ctrl #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned ACC_W  = 40
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     act_base,
    input  logic [ADDR_W-1:0]     wgt_base,
    input  logic [LEN_W-1:0]      num_chunks,
    output logic                  busy,
    output logic                  done,
    output logic [ACC_W-1:0]      result,
    output logic                  result_valid,
    output logic                  act_rd_en,
    output logic                  wgt_rd_en,
    output logic [ADDR_W-1:0]     act_rd_addr,
    output logic [ADDR_W-1:0]     wgt_rd_addr,
    input  logic [LANE_BUS_W-1:0] act_rd_data,
    input  logic [LANE_BUS_W-1:0] wgt_rd_data,
    output logic                  pe_enable,
    output logic [LANE_BUS_W-1:0] pe_act,
    output logic [LANE_BUS_W-1:0] pe_wgt,
    input  logic [PE_RES_W-1:0]   pe_result
);

    state_t             r_state, w_state_nxt;
    logic [LEN_W-1:0]   r_len, w_len_nxt;
    logic [LEN_W-1:0]   r_idx, w_idx_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_rv, w_rv_nxt;
    logic               r_rd_en, w_rd_en_nxt;
    logic [ADDR_W-1:0]  r_act_addr, w_act_addr_nxt;
    logic [ADDR_W-1:0]  r_wgt_addr, w_wgt_addr_nxt;
    logic               w_clear;
    logic               w_flush;
    logic [PE_LAT:0]    w_vld;
    logic [ACC_W-1:0]   w_acc;

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rv       <= 1'b0;
            r_rd_en    <= 1'b0;
            r_act_addr <= '0;
            r_wgt_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len_nxt;
            r_idx      <= w_idx_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_rv       <= w_rv_nxt;
            r_rd_en    <= w_rd_en_nxt;
            r_act_addr <= w_act_addr_nxt;
            r_wgt_addr <= w_wgt_addr_nxt;
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        w_state_nxt    = r_state;
        w_len_nxt      = r_len;
        w_idx_nxt      = r_idx;
        w_rv_nxt       = r_rv;
        w_rd_en_nxt    = 1'b0;
        w_act_addr_nxt = '0;
        w_wgt_addr_nxt = '0;
        w_clear        = 1'b0;
        w_flush        = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_clear  = 1'b1;
                    w_rv_nxt = 1'b0;
                    if (num_chunks != '0) begin
                        w_state_nxt    = ST_FETCH;
                        w_len_nxt      = num_chunks;
                        w_idx_nxt      = '0;
                        w_rd_en_nxt    = 1'b1;
                        w_act_addr_nxt = act_base;
                        w_wgt_addr_nxt = wgt_base;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_flush     = 1'b1;
                end else if (r_idx == r_len - LEN_W'(1)) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_rd_en_nxt    = 1'b1;
                    w_idx_nxt      = r_idx + LEN_W'(1);
                    w_act_addr_nxt = r_act_addr + ADDR_W'(1);
                    w_wgt_addr_nxt = r_wgt_addr + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                // Done once only the final PE-result stage can still be set;
                // it is summed on the same edge that enters DONE.
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_flush     = 1'b1;
                end else if (w_vld[PE_LAT-1:0] == '0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_DRAIN);
        w_done_nxt = (w_state_nxt == ST_DONE);
        if (w_state_nxt == ST_DONE) begin
            w_rv_nxt = 1'b1;
        end
    end

    ip_seq_accum #(
        .ACC_W (ACC_W)
    ) u_accum (
        .clk         (clk),
        .rst_n       (reset),
        .i_issue     (r_rd_en),
        .i_clear     (w_clear),
        .i_flush     (w_flush),
        .i_pe_result (pe_result),
        .o_vld       (w_vld),
        .o_acc       (w_acc)
    );

    assign busy         = r_busy;
    assign pe_enable    = r_busy;
    assign done         = r_done;
    assign result_valid = r_rv;
    assign result       = w_acc;
    assign act_rd_en    = r_rd_en;
    assign wgt_rd_en    = r_rd_en;
    assign act_rd_addr  = r_act_addr;
    assign wgt_rd_addr  = r_wgt_addr;

    // Read data reaches the PE only in the cycle after its read was issued.
    assign pe_act = w_vld[0] ? act_rd_data : '0;
    assign pe_wgt = w_vld[0] ? wgt_rd_data : '0;

endmodule
